fp32_mul_operand_stage: RTL and testbench
=========================================

Name: fp32_mul_operand_stage

Overview:
- Registered operand-issue stage directly upstream of the combinational FP32 multiplier datapath.
- Accepts raw IEEE-754 binary32 operand pairs over a valid/ready handshake and splits each operand into sign / exponent / mantissa / is_denorm fields, which drive the multiplier's field inputs.
- Classifies special operands (zero, infinity, NaN) and precomputes a bypass result, because the multiplier datapath does not handle those operands.
- Provides one register stage plus a skid entry, giving full throughput with a registered in_ready.

Parameters:
- DAZ, 0, denormals-are-zero. When 1, denormal inputs are treated as signed zero for classification and mantissa output.
- QNAN, 32'h7FC00000, canonical quiet NaN emitted for every NaN result.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept; driven directly from a register (not combinational from out_ready)
- in_a  in  32  operand A, raw binary32
- in_b  in  32  operand B, raw binary32
- out_valid  out  1  output fields valid
- out_ready  in  1  downstream accepts
- sign_a, sign_b  out  1 each  operand signs
- exponent_a, exponent_b  out  8 each  biased exponents
- mantissa_a, mantissa_b  out  23 each  fraction bits; forced to 0 when the operand is DAZ-flushed
- is_denorm_a, is_denorm_b  out  1 each  exponent==0 (also 1 for ±0)
- out_special  out  1  result is fully determined by special-case logic; downstream selects out_special_result
- out_special_result  out  32  bypass result; 0 when out_special=0

Behaviour:
- Reset (asynchronous, active-low):
  - main and skid entries invalid; out_valid=0; in_ready=1.
  - All data outputs 0.
  - Reset mid-transfer discards both entries; no partial beat appears after release.
- Classification per operand x, combinational on input, stored with the beat:
  - zero: exp==0 && (frac==0 || DAZ)
  - inf: exp==255 && frac==0
  - nan: exp==255 && frac!=0
- Special result, in priority order (s = sign_a ^ sign_b):
  - any NaN, or inf×zero: out_special=1, result QNAN (sign bit 0).
  - else any inf: {s, 8'hFF, 23'h0}.
  - else any zero: {s, 31'h0}.
  - else out_special=0, result 0.
- Field outputs are always the raw split (sign = bit31, exponent = [30:23], mantissa = [22:0]), except when DAZ=1 and the operand is denormal (mantissa forced to 0).
- Latency: exactly 1 cycle. A beat accepted at edge N is on the outputs with out_valid=1 after edge N when the main entry is empty or draining.
- Handshake:
  - Transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
  - Outputs stay stable while out_valid && !out_ready.
  - in_valid does not depend on in_ready.
- Skid behaviour:
  - in_ready = !skid_valid, registered.
  - If a beat is accepted while the main entry is valid and not draining, it goes into the skid entry and in_ready drops the next cycle.
  - When the main entry drains with the skid full, the skid moves to main, skid clears, and in_ready returns to 1 the next cycle.
  - Simultaneous accept and drain with the skid empty: the new beat goes straight into main; out_valid stays 1; no bubble.
- Ordering: strict FIFO; no beat is dropped or duplicated; maximum occupancy 2.
- No state other than the two entries. No counters survive reset.

Test Plan:
- Normal pair: in_a=32'h3FC00000 (1.5), in_b=32'h40000000 (2.0), out_ready=1 -> next cycle:
  - sign_a=0, exponent_a=8'h7F, mantissa_a=23'h400000, is_denorm_a=0
  - exponent_b=8'h80, mantissa_b=0
  - out_special=0
- Specials:
  - 32'h7F800000 × 32'h80000000 (inf×−0) -> out_special=1, result 32'h7FC00000.
  - 32'hFF800000 × 32'h3F800000 -> result 32'hFF800000.
  - 32'h7FA00001 × anything -> result 32'h7FC00000.
- DAZ:
  - DAZ=1, in_a=32'h00000001, in_b=32'h3F800000 -> is_denorm_a=1, mantissa_a=0, out_special=1, result 32'h00000000.
  - DAZ=0, same inputs -> mantissa_a=23'h000001, out_special=0.
- Backpressure: stream 4 beats A0..A3 with in_valid=1 every cycle while out_ready=0 -> A0 held in main, A1 in skid, in_ready=0 from the cycle after A1 is accepted. Then raise out_ready -> outputs A0, A1, A2, A3 in order on consecutive cycles, with in_ready=1 again the cycle after A0 drains.
- Full throughput: in_valid=1 and out_ready=1 for 16 cycles -> 16 outputs, no bubbles, in_ready constantly 1.
- Reset mid-operation: main and skid both full, assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and in_ready=1 immediately (before the next edge); after release, the first output is the first beat presented post-reset.

Source files
------------

// File: rtl/fp32_mul_operand_stage_if.sv
// Operand-issue handshake bundle: raw binary32 pair in, split multiplier fields out.
interface fp32_mul_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exponent_a;
    logic [7:0]  exponent_b;
    logic [22:0] mantissa_a;
    logic [22:0] mantissa_b;
    logic        is_denorm_a;
    logic        is_denorm_b;
    logic        out_special;
    logic [31:0] out_special_result;

    // Master is the producer of operands and consumer of fields.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, sign_a, sign_b, exponent_a, exponent_b,
        input  mantissa_a, mantissa_b, is_denorm_a, is_denorm_b,
        input  out_special, out_special_result
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, sign_a, sign_b, exponent_a, exponent_b,
        output mantissa_a, mantissa_b, is_denorm_a, is_denorm_b,
        output out_special, out_special_result
    );
endinterface

// File: rtl/fp32_mul_operand_stage.sv
// Registered FP32 multiplier operand stage: field split, special-case bypass
// result, one main entry plus one skid entry behind a registered in_ready.
module fp32_mul_operand_stage #(
    parameter bit          DAZ  = 1'b0,
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input logic                     clk,
    input logic                     rst_n,
    fp32_mul_operand_stage_if.slave bus
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
        logic        is_denorm;
    } field_t;

    typedef struct packed {
        field_t      a;
        field_t      b;
        logic        special;
        logic [31:0] special_result;
    } entry_t;

    function automatic logic op_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00) && ((x[22:0] == 23'h0) || DAZ);
    endfunction

    function automatic logic op_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    endfunction

    function automatic logic op_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    function automatic field_t split_op(input logic [31:0] x);
        field_t f;
        f.sign      = x[31];
        f.exponent  = x[30:23];
        f.is_denorm = (x[30:23] == 8'h00);
        f.mantissa  = (DAZ && f.is_denorm) ? 23'h0 : x[22:0];
        return f;
    endfunction

    // Returns {special, bypass_result}; checks run in priority order.
    function automatic logic [32:0] special_of(input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = a[31] ^ b[31];
        if (op_nan(a) || op_nan(b) || (op_inf(a) && op_zero(b)) || (op_zero(a) && op_inf(b)))
            return {1'b1, QNAN};
        else if (op_inf(a) || op_inf(b))
            return {1'b1, s, 8'hFF, 23'h0};
        else if (op_zero(a) || op_zero(b))
            return {1'b1, s, 31'h0};
        else
            return 33'h0;
    endfunction

    entry_t      entry_p0;
    logic [32:0] spec_p0;

    entry_t main_p1;
    entry_t skid_p1;
    logic   main_vld_p1;
    logic   skid_vld_p1;
    logic   rdy_p1;

    logic in_fire;
    logic out_fire;
    logic main_free;
    logic main_vld_nx;
    logic skid_vld_nx;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Stage 0: classify and split the incoming pair.
    always_comb begin
        spec_p0                 = special_of(bus.in_a, bus.in_b);
        entry_p0.a              = split_op(bus.in_a);
        entry_p0.b              = split_op(bus.in_b);
        entry_p0.special        = spec_p0[32];
        entry_p0.special_result = spec_p0[31:0];
    end

    assign in_fire   = bus.in_valid && rdy_p1;
    assign out_fire  = main_vld_p1 && bus.out_ready;
    assign main_free = !main_vld_p1 || out_fire;

    // A full skid implies in_ready was low, so no new beat competes with the refill.
    always_comb begin
        main_vld_nx    = main_vld_p1;
        skid_vld_nx    = skid_vld_p1;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (main_free) begin
            if (skid_vld_p1) begin
                load_main_skid = 1'b1;
                main_vld_nx    = 1'b1;
                skid_vld_nx    = 1'b0;
            end else if (in_fire) begin
                load_main_in = 1'b1;
                main_vld_nx  = 1'b1;
            end else begin
                main_vld_nx = 1'b0;
            end
        end else if (in_fire) begin
            load_skid   = 1'b1;
            skid_vld_nx = 1'b1;
        end
    end

    // Stage 1: main and skid entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else begin
            main_vld_p1 <= main_vld_nx;
            skid_vld_p1 <= skid_vld_nx;
            rdy_p1      <= !skid_vld_nx;
            if (load_main_skid)
                main_p1 <= skid_p1;
            else if (load_main_in)
                main_p1 <= entry_p0;
            if (load_skid)
                skid_p1 <= entry_p0;
        end
    end

    assign bus.in_ready           = rdy_p1;
    assign bus.out_valid          = main_vld_p1;
    assign bus.sign_a             = main_p1.a.sign;
    assign bus.exponent_a         = main_p1.a.exponent;
    assign bus.mantissa_a         = main_p1.a.mantissa;
    assign bus.is_denorm_a        = main_p1.a.is_denorm;
    assign bus.sign_b             = main_p1.b.sign;
    assign bus.exponent_b         = main_p1.b.exponent;
    assign bus.mantissa_b         = main_p1.b.mantissa;
    assign bus.is_denorm_b        = main_p1.b.is_denorm;
    assign bus.out_special        = main_p1.special;
    assign bus.out_special_result = main_p1.special_result;

endmodule

// File: tb/tb_fp32_mul_operand_stage.sv
// Bench for fp32_mul_operand_stage: DAZ=0 and DAZ=1 instances share one stimulus
// stream; a queue scoreboard with a category-level FP model checks every output beat.
module tb_fp32_mul_operand_stage;

    typedef struct packed {
        logic        sign_a;
        logic [7:0]  exponent_a;
        logic [22:0] mantissa_a;
        logic        is_denorm_a;
        logic        sign_b;
        logic [7:0]  exponent_b;
        logic [22:0] mantissa_b;
        logic        is_denorm_b;
        logic        special;
        logic [31:0] result;
    } beat_t;

    typedef enum {C_FIN, C_ZERO, C_INF, C_NAN} cls_e;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sp0;
        logic [31:0] res0;
        logic [22:0] man0;
        logic        sp1;
        logic [31:0] res1;
        logic [22:0] man1;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        da;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   fires0;
    beat_t q0[$];
    beat_t q1[$];
    beat_t act0;
    beat_t act1;
    vec_t  tbl[8];

    fp32_mul_operand_stage_if if0();
    fp32_mul_operand_stage_if if1();

    fp32_mul_operand_stage #(.DAZ(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    fp32_mul_operand_stage #(.DAZ(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    assign if1.in_valid  = if0.in_valid;
    assign if1.in_a      = if0.in_a;
    assign if1.in_b      = if0.in_b;
    assign if1.out_ready = if0.out_ready;

    assign act0 = {if0.sign_a, if0.exponent_a, if0.mantissa_a, if0.is_denorm_a,
                   if0.sign_b, if0.exponent_b, if0.mantissa_b, if0.is_denorm_b,
                   if0.out_special, if0.out_special_result};
    assign act1 = {if1.sign_a, if1.exponent_a, if1.mantissa_a, if1.is_denorm_a,
                   if1.sign_b, if1.exponent_b, if1.mantissa_b, if1.is_denorm_b,
                   if1.out_special, if1.out_special_result};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [98:0] act, input logic [98:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, want);
        end
    endtask

    function automatic cls_e classify(input logic [31:0] x, input bit daz);
        if (x[30:23] == 8'hFF) return (x[22:0] == 23'h0) ? C_INF : C_NAN;
        if (x[30:23] == 8'h00 && (x[22:0] == 23'h0 || daz)) return C_ZERO;
        return C_FIN;
    endfunction

    function automatic beat_t model(input logic [31:0] a, input logic [31:0] b, input bit daz);
        beat_t r;
        cls_e  ca;
        cls_e  cb;
        logic  s;
        ca = classify(a, daz);
        cb = classify(b, daz);
        s  = a[31] ^ b[31];
        r.sign_a      = a[31];
        r.exponent_a  = a[30:23];
        r.is_denorm_a = (a[30:23] == 8'h00);
        r.mantissa_a  = (daz && r.is_denorm_a) ? 23'h0 : a[22:0];
        r.sign_b      = b[31];
        r.exponent_b  = b[30:23];
        r.is_denorm_b = (b[30:23] == 8'h00);
        r.mantissa_b  = (daz && r.is_denorm_b) ? 23'h0 : b[22:0];
        if (ca == C_NAN || cb == C_NAN || (ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF)) begin
            r.special = 1'b1; r.result = 32'h7FC00000;
        end else if (ca == C_INF || cb == C_INF) begin
            r.special = 1'b1; r.result = {s, 8'hFF, 23'h0};
        end else if (ca == C_ZERO || cb == C_ZERO) begin
            r.special = 1'b1; r.result = {s, 31'h0};
        end else begin
            r.special = 1'b0; r.result = 32'h0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic        s;
        r = $urandom;
        s = r[31];
        case ($urandom_range(0, 7))
            0: return {s, 31'h0};
            1: return {s, 8'hFF, 23'h0};
            2: return {s, 8'hFF, r[22:1], 1'b1};
            3: return {s, 8'h00, r[22:1], 1'b1};
            default: return r;
        endcase
    endfunction

    // Scoreboards: status against occupancy, then the transfer at the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid0", if0.out_valid, q0.size() > 0);
            check("in_ready0", if0.in_ready, q0.size() < 2);
            if (if0.out_valid && if0.out_ready) begin
                if (q0.size() == 0) check("beat0_unexpected", if0.out_valid, 0);
                else begin check("beat0", act0, q0.pop_front()); fires0++; end
            end
            if (if0.in_valid && if0.in_ready) q0.push_back(model(if0.in_a, if0.in_b, 1'b0));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid1", if1.out_valid, q1.size() > 0);
            check("in_ready1", if1.in_ready, q1.size() < 2);
            if (if1.out_valid && if1.out_ready) begin
                if (q1.size() == 0) check("beat1_unexpected", if1.out_valid, 0);
                else check("beat1", act1, q1.pop_front());
            end
            if (if1.in_valid && if1.in_ready) q1.push_back(model(if1.in_a, if1.in_b, 1'b1));
        end
    end

    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
    end

    // Presents one beat from posedge+1 and returns at posedge+1 after it is taken.
    task automatic send(input logic [31:0] a, input logic [31:0] b, output int tries);
        bit r;
        r = 1'b0;
        tries = 0;
        if0.in_valid = 1'b1;
        if0.in_a = a;
        if0.in_b = b;
        while (!r && tries < 50) begin
            tries++;
            @(negedge clk);
            r = if0.in_ready;
            @(posedge clk);
            #1;
        end
        if (!r) check("send_timeout", if0.in_ready, 1);
    endtask

    initial begin
        int n;
        int snap;
        checks = 0;
        errors = 0;
        fires0 = 0;
        rst_n = 1'b0;
        if0.in_valid = 1'b0;
        if0.in_a = 32'h0;
        if0.in_b = 32'h0;
        if0.out_ready = 1'b0;

        tbl[0] = '{32'h3FC00000, 32'h40000000, 1'b0, 32'h0,        23'h400000, 1'b0, 32'h0,        23'h400000, 8'h7F, 8'h80, 1'b0};
        tbl[1] = '{32'h7F800000, 32'h80000000, 1'b1, 32'h7FC00000, 23'h0,      1'b1, 32'h7FC00000, 23'h0,      8'hFF, 8'h00, 1'b0};
        tbl[2] = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 23'h0,      1'b1, 32'hFF800000, 23'h0,      8'hFF, 8'h7F, 1'b0};
        tbl[3] = '{32'h7FA00001, 32'h12345678, 1'b1, 32'h7FC00000, 23'h200001, 1'b1, 32'h7FC00000, 23'h200001, 8'hFF, 8'h24, 1'b0};
        tbl[4] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h0,        23'h000001, 1'b1, 32'h0,        23'h0,      8'h00, 8'h7F, 1'b1};
        tbl[5] = '{32'h80000000, 32'h3F800000, 1'b1, 32'h80000000, 23'h0,      1'b1, 32'h80000000, 23'h0,      8'h00, 8'h7F, 1'b1};
        tbl[6] = '{32'h80000001, 32'h7F800000, 1'b1, 32'hFF800000, 23'h000001, 1'b1, 32'h7FC00000, 23'h0,      8'h00, 8'hFF, 1'b1};
        tbl[7] = '{32'h00000000, 32'h7FC00000, 1'b1, 32'h7FC00000, 23'h0,      1'b1, 32'h7FC00000, 23'h0,      8'h00, 8'hFF, 1'b1};

        #22;
        check("rst_out_valid0", if0.out_valid, 0);
        check("rst_in_ready0", if0.in_ready, 1);
        check("rst_result0", if0.out_special_result, 0);
        check("rst_exponent_a0", if0.exponent_a, 0);
        check("rst_mantissa_b0", if0.mantissa_b, 0);
        check("rst_out_valid1", if1.out_valid, 0);
        check("rst_in_ready1", if1.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one beat at a time.
        if0.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if0.in_valid = 1'b1;
            if0.in_a = tbl[i].a;
            if0.in_b = tbl[i].b;
            @(posedge clk);
            #1;
            if0.in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), if0.out_valid, 1);
            check($sformatf("vec%0d_special0", i), if0.out_special, tbl[i].sp0);
            check($sformatf("vec%0d_result0", i), if0.out_special_result, tbl[i].res0);
            check($sformatf("vec%0d_mant_a0", i), if0.mantissa_a, tbl[i].man0);
            check($sformatf("vec%0d_exp_a0", i), if0.exponent_a, tbl[i].ea);
            check($sformatf("vec%0d_exp_b0", i), if0.exponent_b, tbl[i].eb);
            check($sformatf("vec%0d_denorm_a0", i), if0.is_denorm_a, tbl[i].da);
            check($sformatf("vec%0d_special1", i), if1.out_special, tbl[i].sp1);
            check($sformatf("vec%0d_result1", i), if1.out_special_result, tbl[i].res1);
            check($sformatf("vec%0d_mant_a1", i), if1.mantissa_a, tbl[i].man1);
            @(posedge clk);
            #1;
        end

        // Backpressure: A0 in main, A1 in skid, then drain four in a row.
        if0.out_ready = 1'b0;
        send(32'h3F800000, 32'h40400000, n);
        send(32'h40000000, 32'h40800000, n);
        check("bp_in_ready_low", if0.in_ready, 0);
        check("bp_out_valid", if0.out_valid, 1);
        check("bp_head_exp_a", if0.exponent_a, 8'h7F);
        fork
            begin
                send(32'h40400000, 32'hC0A00000, n);
                send(32'h7F800000, 32'h00000000, n);
                if0.in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                if0.out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check($sformatf("bp_drain%0d_valid", k), if0.out_valid, 1);
                    if (k == 1) check("bp_in_ready_back", if0.in_ready, 1);
                end
                @(negedge clk);
                check("bp_drained", if0.out_valid, 0);
            end
        join
        @(posedge clk);
        #1;

        // Full throughput with both sides always ready.
        snap = fires0;
        for (int k = 0; k < 16; k++) begin
            send(rand_op(), rand_op(), n);
            check($sformatf("tput_tries%0d", k), n, 1);
        end
        if0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("tput_outputs", fires0 - snap, 16);

        // Random traffic on both sides.
        for (int k = 0; k < 400; k++) begin
            if0.in_valid = ($urandom_range(0, 3) != 0);
            if0.in_a = rand_op();
            if0.in_b = rand_op();
            if0.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rand_drain0", q0.size(), 0);
        check("rand_drain1", q1.size(), 0);

        // Reset with both entries full.
        if0.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, n);
        send(32'h40000000, 32'h40000000, n);
        if0.in_valid = 1'b0;
        check("mrst_full", if0.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid0", if0.out_valid, 0);
        check("mrst_in_ready0", if0.in_ready, 1);
        check("mrst_exp_a0", if0.exponent_a, 0);
        check("mrst_out_valid1", if1.out_valid, 0);
        check("mrst_in_ready1", if1.in_ready, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if0.out_ready = 1'b1;
        send(32'h7F800000, 32'h3F800000, n);
        if0.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", if0.out_valid, 1);
        check("post_rst_result", if0.out_special_result, 32'h7F800000);
        check("post_rst_exp_a", if0.exponent_a, 8'hFF);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_empty", if0.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
